tdm_slot_scheduler: RTL
=======================

Name: tdm_slot_scheduler

Overview:
Frame sequencer and round-robin arbiter that shares the single serial TDM channel (Source/Destination pair) between NUM_REQ byte requesters. It owns the frame timing: it generates the timeslot count and the sync pulse. At each frame boundary it grants one requester through a valid/ready handshake. It then holds that byte, its parity and its channel id stable for the whole frame so the serializer can consume them.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, payload width per frame.
FRAME_LEN, 32, timeslots per frame. Legal range is DATA_W+2 to 32. The timeslot port is always 5 bits.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  run request; frames are emitted while high.
req_valid  input  NUM_REQ  per-requester byte-available flag.
req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
req_ready  output  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high.
sync  output  1  high during slot 0 of every running frame.
timeslot  output  5  current slot index.
tx_data  output  DATA_W  payload of the current frame.
tx_parity  output  1  even parity (XOR-reduce) of tx_data.
tx_valid  output  1  current frame carries a granted byte.
tx_chan  output  3  requester id of the current frame.
tx_count  output  8  count of valid frames started, wraps 255 to 0.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - state = IDLE, timeslot = 0, sync = 0.
  - tx_data = 0, tx_parity = 0, tx_valid = 0, tx_chan = 0, tx_count = 0.
  - Round-robin pointer rr_ptr = 0.
  - req_ready is 0 while reset is asserted.
- States: IDLE and RUN.
- IDLE:
  - timeslot holds 0, sync = 0, tx_valid = 0.
  - If enable = 1 the cycle is a boundary cycle; next state is RUN at slot 0.
- RUN:
  - timeslot increments by 1 each cycle and wraps from FRAME_LEN-1 to 0.
  - sync = 1 exactly when timeslot == 0.
  - At slot FRAME_LEN-1: if enable = 1 it is a boundary cycle and the next cycle starts a new frame. If enable = 0 the next state is IDLE with timeslot 0.
  - Dropping enable mid-frame never truncates the frame.
- Boundary cycle arbitration (combinational within the cycle):
  - Search req_valid starting at rr_ptr and moving upward modulo NUM_REQ. The first set bit g is the grant.
  - req_ready = one-hot(g) only in a boundary cycle; it is 0 in every other cycle.
- On the clock edge ending a boundary cycle with grant g:
  - tx_data is loaded from req_data[g] and tx_parity from the XOR of that byte.
  - tx_valid = 1, tx_chan = g, rr_ptr = (g+1) mod NUM_REQ, tx_count increments.
- No valid requester at a boundary (idle frame):
  - tx_data = 0, tx_parity = 0, tx_valid = 0, tx_chan = 0.
  - rr_ptr and tx_count are unchanged.
- tx_data, tx_parity, tx_valid and tx_chan are stable from slot 0 through slot FRAME_LEN-1.
- Latency: a byte handshaken in the boundary cycle appears on tx_data in the next cycle, together with sync = 1 and timeslot = 0.
- Entering IDLE clears tx_valid. tx_data keeps its last value.
- Requesters may change req_valid or req_data at any time. Only the boundary-cycle values matter.

Decomposition:
- Shared package holds:
  - TS_W = 5.
  - Default DATA_W and FRAME_LEN.
  - SLOT_SYNC = 0.
  - State encoding IDLE/RUN.
  - Parity function, shared with the Destination checker.
- One sub-module: rr_arbiter.
  - Parameter: NUM_REQ.
  - Inputs: req, ptr, en.
  - Outputs: grant one-hot, grant_id, any.

Test Plan:
- Reset, enable=1, req_valid=4'b0001, req0=8'hA5. Required:
  - req_ready=4'b0001 in the IDLE boundary cycle.
  - Next cycle: sync=1, timeslot=0, tx_data=8'hA5, tx_parity=0, tx_valid=1, tx_chan=0, tx_count=1.
- All four requesters valid with data 8'h11, 8'h22, 8'h33, 8'h44 for 5 frames:
  - tx_chan sequence is 0,1,2,3,0.
  - tx_data sequence is 11,22,33,44,11.
  - Parity is 0 for every frame.
  - req_ready is one-hot and only high at timeslot 31.
- Continuous run: timeslot wraps 31 to 0, sync pulses for exactly 1 cycle every 32 cycles, and tx_data does not change within a frame.
- Drop enable at slot 10: frame continues to slot 31, then state is IDLE with timeslot=0, sync=0 and tx_valid=0. No req_ready pulse occurs.
- req_valid=0 at a boundary: idle frame with tx_valid=0 and tx_data=0. rr_ptr is unchanged, so a later request from requester 2 with ptr=2 is granted first.
- Assert reset at slot 17 mid-frame: all outputs go to reset values within the same cycle. After release with enable=1, the first grant comes from requester 0.

Source files
------------

// File: rtl/tdm_slot_scheduler_pkg.sv
// tdm_slot_scheduler_pkg: shared constants, state encoding and parity helper
package tdm_slot_scheduler_pkg;
  localparam int TS_W = 5;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_FRAME_LEN = 32;
  localparam int SLOT_SYNC = 0;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  // even parity over a zero-extended word, reused by the destination checker
  function automatic logic parity(input logic [31:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/tdm_slot_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or above ptr
module rr_arbiter
  import tdm_slot_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_id,
  output logic               any
);
  // scan downward so the candidate closest to ptr is written last and wins
  always_comb begin
    int idx;
    grant_id = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (|(req & (NUM_REQ'(1) << idx))) begin
        grant_id = 3'(idx);
        any = en;
      end
    end
    grant = any ? NUM_REQ'(1) << grant_id : '0;
  end
endmodule

// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: TDM frame sequencer with round-robin byte arbitration
module tdm_slot_scheduler
  import tdm_slot_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      sync,
  output logic [TS_W-1:0]           timeslot,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_parity,
  output logic                      tx_valid,
  output logic [2:0]                tx_chan,
  output logic [7:0]                tx_count
);
  logic [0:0] state;
  logic [2:0] rr_ptr, grant_id;
  logic [NUM_REQ-1:0] grant;
  logic any, last, boundary;
  logic [DATA_W-1:0] sel;
  assign last = timeslot == TS_W'(FRAME_LEN - 1);
  assign boundary = enable && (state == IDLE || last);
  assign sync = state == RUN && timeslot == TS_W'(SLOT_SYNC);
  assign req_ready = reset ? '0 : grant;
  assign sel = req_data[int'(grant_id)*DATA_W +: DATA_W];
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .en(boundary),
    .grant(grant),
    .grant_id(grant_id),
    .any(any)
  );
  // frame timing: slot counter runs in RUN and only stops after a full frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      timeslot <= '0;
    end else if (state == IDLE) begin
      state <= enable ? RUN : IDLE;
      timeslot <= '0;
    end else begin
      state <= (last && !enable) ? IDLE : RUN;
      timeslot <= last ? '0 : timeslot + 1'b1;
    end
  // payload capture at boundaries, held for the whole frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_data <= '0;
      tx_parity <= 1'b0;
      tx_valid <= 1'b0;
      tx_chan <= '0;
      tx_count <= '0;
      rr_ptr <= '0;
    end else if (boundary) begin
      tx_data <= any ? sel : '0;
      tx_parity <= any && parity(32'(sel));
      tx_valid <= any;
      tx_chan <= any ? grant_id : '0;
      if (any) begin
        rr_ptr <= grant_id == 3'(NUM_REQ - 1) ? '0 : grant_id + 3'd1;
        tx_count <= tx_count + 8'd1;
      end
    end else if (state == RUN && last) begin
      tx_valid <= 1'b0;
    end
endmodule
